// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW bundle packer: opcode constants, bundle
// field positions, FSM state encoding and the bundle assembly helper.
package vliw_pkg;

    localparam int BUNDLE_W = 32;

    // Scalar opcodes accepted from the op queue (passed through unchecked)
    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_XOR = 8'h04;
    localparam logic [7:0] OP_NOT = 8'h05;

    // Bundle field positions; bits [7:0] are reserved and always zero
    localparam int OPA_HI  = 31;
    localparam int OPA_LO  = 24;
    localparam int OPB_HI  = 23;
    localparam int OPB_LO  = 16;
    localparam int DSTA_HI = 15;
    localparam int DSTA_LO = 12;
    localparam int DSTB_HI = 11;
    localparam int DSTB_LO = 8;

    // IDLE: nothing held, HOLD: slot A occupied, EMIT: bundle register full
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Assemble a bundle word; a single-issue bundle passes slot A twice
    function automatic logic [BUNDLE_W-1:0] make_bundle(
        input logic [7:0] code_a,
        input logic [7:0] code_b,
        input logic [3:0] dst_a,
        input logic [3:0] dst_b
    );
        logic [BUNDLE_W-1:0] w_word;
        w_word                  = '0;
        w_word[OPA_HI:OPA_LO]   = code_a;
        w_word[OPB_HI:OPB_LO]   = code_b;
        w_word[DSTA_HI:DSTA_LO] = dst_a;
        w_word[DSTB_HI:DSTB_LO] = dst_b;
        return w_word;
    endfunction

endpackage

// File: rtl/vliw_hold_timer.sv
// Hold timer for slot A: saturating cycle counter with synchronous clear and
// a timeout flag raised on the last allowed waiting cycle.
// HOLD_TIMEOUT = 0 disables the timeout (slot A waits forever).
module vliw_hold_timer #(
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_timeout
);

    localparam int TMR_W = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT);

    logic [TMR_W-1:0] r_count;

    // Count waiting cycles, clear on request, hold at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

    generate
        if (HOLD_TIMEOUT == 0) begin : g_no_timeout
            assign o_timeout = 1'b0;
        end else begin : g_timeout
            assign o_timeout = (r_count == TMR_W'(HOLD_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/vliw_bundle_packer.sv
// VLIW bundle packer: pairs scalar ops into 32-bit dual-issue bundles for the
// dual-ALU core. A WAW conflict, flush or hold timeout emits slot A alone as a
// single-issue bundle (slot B duplicates slot A).
// Optional feature macro: VLIW_PACK_STATS_EN builds the pair/single counters;
// without it the stat ports are tied to zero.
module vliw_bundle_packer
    import vliw_pkg::*;
#(
    parameter int HOLD_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [7:0]          op_code,
    input  logic [3:0]          op_dst,
    input  logic                flush,
    output logic                bundle_valid,
    input  logic                bundle_ready,
    output logic [BUNDLE_W-1:0] bundle,
    output logic [CNT_W-1:0]    stat_pairs,
    output logic [CNT_W-1:0]    stat_singles
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_a_code;
    logic [7:0]          w_a_code_nxt;
    logic [3:0]          r_a_dst;
    logic [3:0]          w_a_dst_nxt;
    logic                r_pending;
    logic                w_pending_nxt;
    logic [BUNDLE_W-1:0] r_bundle;
    logic [BUNDLE_W-1:0] w_bundle_nxt;

    logic w_op_fire;
    logic w_timeout;
    logic w_tmr_inc;

    // Ready depends on state only, so there is no op_valid -> op_ready path
    assign op_ready     = (r_state != EMIT);
    assign bundle_valid = (r_state == EMIT);
    assign bundle       = r_bundle;
    assign w_op_fire    = op_valid & op_ready;

    // Timer runs only while slot A waits without a partner arriving
    assign w_tmr_inc = (r_state == HOLD) && !w_op_fire;

    vliw_hold_timer #(
        .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (!w_tmr_inc),
        .i_inc    (w_tmr_inc),
        .o_timeout(w_timeout)
    );

    // Next-state and next-datapath decode for the packing FSM
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_nxt   = r_state;
        w_a_code_nxt  = r_a_code;
        w_a_dst_nxt   = r_a_dst;
        w_pending_nxt = r_pending;
        w_bundle_nxt  = r_bundle;

        case (r_state)
            IDLE: begin
                if (w_op_fire) begin
                    w_a_code_nxt = op_code;
                    w_a_dst_nxt  = op_dst;
                    w_state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (w_op_fire) begin
                    if (op_dst != r_a_dst) begin
                        w_bundle_nxt  = make_bundle(r_a_code, op_code, r_a_dst, op_dst);
                        w_pending_nxt = 1'b0;
                    end else begin
                        // WAW: issue A alone, B waits in slot A for its own partner
                        w_bundle_nxt  = make_bundle(r_a_code, r_a_code, r_a_dst, r_a_dst);
                        w_a_code_nxt  = op_code;
                        w_a_dst_nxt   = op_dst;
                        w_pending_nxt = 1'b1;
                    end
                    w_state_nxt = EMIT;
                end else if (flush || w_timeout) begin
                    w_bundle_nxt  = make_bundle(r_a_code, r_a_code, r_a_dst, r_a_dst);
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (bundle_ready) begin
                    w_state_nxt   = r_pending ? HOLD : IDLE;
                    w_pending_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any held op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a_code  <= '0;
            r_a_dst   <= '0;
            r_pending <= 1'b0;
            r_bundle  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_a_code  <= w_a_code_nxt;
            r_a_dst   <= w_a_dst_nxt;
            r_pending <= w_pending_nxt;
            r_bundle  <= w_bundle_nxt;
        end
    end

`ifdef VLIW_PACK_STATS_EN
    logic [CNT_W-1:0] r_stat_pairs;
    logic [CNT_W-1:0] r_stat_singles;
    logic             w_out_fire;
    logic             w_is_pair;

    assign w_out_fire = bundle_valid & bundle_ready;
    // A pair always has distinct destinations; a single duplicates slot A
    assign w_is_pair  = (r_bundle[DSTA_HI:DSTA_LO] != r_bundle[DSTB_HI:DSTB_LO]);

    // Saturating counters of consumed dual- and single-issue bundles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pairs   <= '0;
            r_stat_singles <= '0;
        end else if (w_out_fire) begin
            if (w_is_pair && (r_stat_pairs != '1)) begin
                r_stat_pairs <= r_stat_pairs + CNT_W'(1);
            end
            if (!w_is_pair && (r_stat_singles != '1)) begin
                r_stat_singles <= r_stat_singles + CNT_W'(1);
            end
        end
    end

    assign stat_pairs   = r_stat_pairs;
    assign stat_singles = r_stat_singles;
`else
    assign stat_pairs   = '0;
    assign stat_singles = '0;
`endif

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Directed testbench for vliw_bundle_packer: pairing, WAW singles, timeout,
// flush priority, back-pressure and reset while holding or emitting.
module tb_vliw_bundle_packer;
    import vliw_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_code;
    logic [3:0]  op_dst;
    logic        flush;
    logic        bundle_valid;
    logic        bundle_ready;
    logic [31:0] bundle;
    logic [15:0] stat_pairs;
    logic [15:0] stat_singles;

    int total;
    int bad;
    int n;
    bit seen;

    vliw_bundle_packer #(
        .HOLD_TIMEOUT(16),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_dst      (op_dst),
        .flush       (flush),
        .bundle_valid(bundle_valid),
        .bundle_ready(bundle_ready),
        .bundle      (bundle),
        .stat_pairs  (stat_pairs),
        .stat_singles(stat_singles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Offer one op and return 1 time unit after the edge that accepts it
    task automatic send_op(input logic [7:0] c, input logic [3:0] d);
        bit done;
        done     = 1'b0;
        op_valid = 1'b1;
        op_code  = c;
        op_dst   = d;
        for (int k = 0; k < 50 && !done; k++) begin
            if (op_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        check("send_accepted", {31'd0, done}, 32'd1);
    endtask

    // Number of clock edges until bundle_valid is seen (-1 if never)
    task automatic wait_valid(output int cnt);
        cnt = -1;
        for (int i = 0; i <= 40; i++) begin
            if (bundle_valid) begin
                cnt = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Let the consumer take the current bundle and confirm the register empties
    task automatic consume(input string tag);
        @(posedge clk);
        #1;
        check(tag, {31'd0, bundle_valid}, 32'd0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        op_valid     = 1'b0;
        op_code      = '0;
        op_dst       = '0;
        flush        = 1'b0;
        bundle_ready = 1'b1;

        // Reset state
        #12;
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_valid", {31'd0, bundle_valid}, 32'd0);
        check("rst_bundle", bundle, 32'h0);
        check("rst_stat_pairs", {16'd0, stat_pairs}, 32'd0);
        check("rst_stat_singles", {16'd0, stat_singles}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: back-to-back pair
        send_op(OP_ADD, 4'd1);
        send_op(OP_AND, 4'd2);
        wait_valid(n);
        check("t1_latency", n, 32'd0);
        check("t1_bundle", bundle, 32'h0002_1200);
        consume("t1_drain");

        // 2: WAW single, then pending op flushed by timeout
        send_op(OP_SUB, 4'd3);
        send_op(OP_XOR, 4'd3);
        wait_valid(n);
        check("t2_waw_latency", n, 32'd0);
        check("t2_waw_bundle", bundle, 32'h0101_3300);
        @(posedge clk);
        #1;
        check("t2_pending_held", {31'd0, bundle_valid}, 32'd0);
        wait_valid(n);
        check("t2_timeout_latency", n, 32'd16);
        check("t2_timeout_bundle", bundle, 32'h0404_3300);
        consume("t2_drain");

        // 3: lone op released by timeout exactly 16 cycles after accept
        send_op(OP_OR, 4'd5);
        wait_valid(n);
        check("t3_timeout_latency", n, 32'd16);
        check("t3_bundle", bundle, 32'h0303_5500);
        consume("t3_drain");

        // 4a: flush releases slot A
        send_op(OP_NOT, 4'd7);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_valid(n);
        check("t4_flush_latency", n, 32'd0);
        check("t4_flush_bundle", bundle, 32'h0505_7700);
        consume("t4_flush_drain");

        // 4b: op arriving with flush wins and forms a pair
        send_op(OP_NOT, 4'd7);
        flush = 1'b1;
        send_op(OP_ADD, 4'd8);
        flush = 1'b0;
        wait_valid(n);
        check("t4_pair_latency", n, 32'd0);
        check("t4_pair_bundle", bundle, 32'h0500_7800);
        consume("t4_pair_drain");

`ifdef VLIW_PACK_STATS_EN
        check("stat_pairs", {16'd0, stat_pairs}, 32'd2);
        check("stat_singles", {16'd0, stat_singles}, 32'd4);
`else
        check("stat_pairs_tied", {16'd0, stat_pairs}, 32'd0);
        check("stat_singles_tied", {16'd0, stat_singles}, 32'd0);
`endif

        // 5: back-pressure with a new op offered during the stall
        bundle_ready = 1'b0;
        send_op(OP_AND, 4'd9);
        send_op(OP_OR, 4'd10);
        op_valid = 1'b1;
        op_code  = OP_XOR;
        op_dst   = 4'd11;
        for (int i = 0; i < 10; i++) begin
            check("t5_stall_valid", {31'd0, bundle_valid}, 32'd1);
            check("t5_stall_bundle", bundle, 32'h0203_9A00);
            check("t5_stall_op_ready", {31'd0, op_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bundle_ready = 1'b1;
        send_op(OP_XOR, 4'd11);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("t5_late_op_valid", {31'd0, bundle_valid}, 32'd1);
        check("t5_late_op_bundle", bundle, 32'h0404_BB00);
        consume("t5_drain");

        // 6a: reset while holding an op
        send_op(OP_SUB, 4'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_hold_rst_valid", {31'd0, bundle_valid}, 32'd0);
        check("t6_hold_rst_op_ready", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bundle_valid) seen = 1'b1;
        end
        flush = 1'b0;
        check("t6_hold_no_ghost", {31'd0, seen}, 32'd0);

        // 6b: reset while a bundle waits for the consumer
        bundle_ready = 1'b0;
        send_op(OP_AND, 4'd13);
        send_op(OP_OR, 4'd14);
        check("t6_emit_before_rst", {31'd0, bundle_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_emit_rst_valid", {31'd0, bundle_valid}, 32'd0);
        check("t6_emit_rst_bundle", bundle, 32'h0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bundle_ready = 1'b1;
        seen         = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bundle_valid) seen = 1'b1;
        end
        check("t6_emit_no_ghost", {31'd0, seen}, 32'd0);
        check("t6_stat_pairs_rst", {16'd0, stat_pairs}, 32'd0);
        check("t6_stat_singles_rst", {16'd0, stat_singles}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
